seg_monitor: RTL

SEG_MONITOR -- requirements
Module: seg_monitor

---
 rtl/seg_monitor_if.sv | 19 +
 rtl/seg_monitor.sv | 91 +++++++++
 2 files changed

// File: rtl/seg_monitor_if.sv
// seg_monitor_if: segment bus in, decoded digit and status out.
interface seg_monitor_if;
  logic [6:0] leds;
  logic [3:0] digit;
  logic       digit_valid;
  logic       bad_pattern;
  logic       seq_err;
  logic       blank;
  logic [7:0] accept_count;
  logic [7:0] err_count;
  modport master (
    output leds,
    input  digit, digit_valid, bad_pattern, seq_err, blank, accept_count, err_count
  );
  modport slave (
    input  leds,
    output digit, digit_valid, bad_pattern, seq_err, blank, accept_count, err_count
  );
endinterface

// File: rtl/seg_monitor.sv
// seg_monitor: debounces an async 7-segment bus, decodes hex and flags bad or out-of-order digits.
module seg_monitor #(
  parameter int STABLE_CYCLES = 4
) (
  input logic clk,
  input logic SW0,
  seg_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  state_t state_q, state_d;
  logic [6:0] s1_q, s2_q, seg, prev_q, acc_q;
  logic [7:0] cnt_q, cnt_d, acnt_q, acnt_d, ecnt_q, ecnt_d;
  logic [3:0] digit_q, digit_d, dec;
  logic acc_vld_q, ref_vld_q, ref_vld_d;
  logic dv_q, dv_d, bad_q, bad_d, seqe_q, seqe_d, blank_q, blank_d;
  logic hit, changed, accept, take_hex, take_bad, take_blank, seq_bad;
  assign seg = ~s2_q;
  assign changed = seg != prev_q;
  assign cnt_d = changed ? 8'd0 : (cnt_q == CNT_MAX ? cnt_q : cnt_q + 8'd1);
  // the candidate is prev_q: the counter measures how long that value has been held
  assign accept = state_q == SETTLE && cnt_q == CNT_MAX && (!acc_vld_q || prev_q != acc_q);
  always_comb begin
    dec = 4'd0;
    hit = 1'b0;
    for (int i = 0; i < 16; i++) if (prev_q == HEX[i]) begin dec = 4'(i); hit = 1'b1; end
  end
  assign take_blank = accept && prev_q == 7'd0;
  assign take_hex = accept && hit;
  assign take_bad = accept && !hit && prev_q != 7'd0;
  assign seq_bad = take_hex && ref_vld_q && dec != digit_q + 4'd1 && dec != 4'd0;
  always_ff @(posedge clk or negedge SW0)
    if (!SW0) state_q <= IDLE;
    else state_q <= state_d;
  // an accept coinciding with a new change must keep settling for the new pattern
  always_comb
    state_d = state_q == IDLE ? SETTLE :
              state_q == LOCKED ? (changed ? SETTLE : LOCKED) :
              (accept && !changed ? LOCKED : SETTLE);
  always_comb begin
    digit_d = take_hex ? dec : digit_q;
    dv_d = take_hex;
    bad_d = take_bad;
    seqe_d = seq_bad;
    blank_d = accept ? take_blank : blank_q;
    acnt_d = acnt_q + {7'd0, take_hex};
    ecnt_d = (take_bad || seq_bad) && ecnt_q != 8'hFF ? ecnt_q + 8'd1 : ecnt_q;
    ref_vld_d = take_hex ? 1'b1 : (take_blank ? 1'b0 : ref_vld_q);
  end
  always_ff @(posedge clk or negedge SW0)
    if (!SW0) begin
      s1_q <= 7'h7F;
      s2_q <= 7'h7F;
      prev_q <= 7'd0;
      cnt_q <= 8'd0;
      acc_q <= 7'd0;
      acc_vld_q <= 1'b0;
      ref_vld_q <= 1'b0;
      digit_q <= 4'd0;
      dv_q <= 1'b0;
      bad_q <= 1'b0;
      seqe_q <= 1'b0;
      blank_q <= 1'b0;
      acnt_q <= 8'd0;
      ecnt_q <= 8'd0;
    end else begin
      s1_q <= bus.leds;
      s2_q <= s1_q;
      prev_q <= seg;
      cnt_q <= cnt_d;
      acc_q <= accept ? prev_q : acc_q;
      acc_vld_q <= acc_vld_q | accept;
      ref_vld_q <= ref_vld_d;
      digit_q <= digit_d;
      dv_q <= dv_d;
      bad_q <= bad_d;
      seqe_q <= seqe_d;
      blank_q <= blank_d;
      acnt_q <= acnt_d;
      ecnt_q <= ecnt_d;
    end
  assign bus.digit = digit_q;
  assign bus.digit_valid = dv_q;
  assign bus.bad_pattern = bad_q;
  assign bus.seq_err = seqe_q;
  assign bus.blank = blank_q;
  assign bus.accept_count = acnt_q;
  assign bus.err_count = ecnt_q;
endmodule
